trap_seq_ctrl: RTL
==================

Name: trap_seq_ctrl

Overview:
- Sequences machine-mode trap entry (ecall, machine timer interrupt) and trap return (mret) for the RV64 core's CSR file and pipeline.
- Sits between the commit stage and the CSR file.
- On a trap event it stalls and flushes the pipeline, waits for outstanding memory traffic to drain, and issues a single-cycle CSR update strobe with cause and EPC.
- It then redirects fetch to mtvec (trap) or mepc (return).

Parameters:
XLEN, 64, datapath/PC width
DRAIN_TIMEOUT, 255, max DRAIN cycles before forced progress
CNT_W, 32, width of trap/return event counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
cmt_valid  in  1  commit stage presents an instruction this cycle
cmt_pc  in  XLEN  PC of committing instruction
cmt_ecall  in  1  committing instruction is ecall
cmt_mret  in  1  committing instruction is mret
tmr_irq_pend  in  1  mip.MTIP & mstatus.MIE & mie.MTIE (level)
mem_busy  in  1  LSU/bus transaction outstanding
ex_stall  in  1  execute stage stalled; CSR strobe must not issue
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
stall_req  out  1  hold fetch/decode/execute
flush  out  1  kill younger in-flight instructions
ecall_trap_ena  out  1  CSR trap-entry strobe, ecall cause
tmr_trap_ena  out  1  CSR trap-entry strobe, timer cause
cmt_mret_ena  out  1  CSR mret strobe
trap_mcause_value  out  XLEN  mcause to write
trap_epc  out  XLEN  mepc write data
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  XLEN  redirect target
drain_err  out  1  sticky: DRAIN timed out
trap_cnt  out  CNT_W  trap entries taken
mret_cnt  out  CNT_W  mret returns taken

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; latches 0.
- Reset mid-operation forces IDLE in the next cycle. No strobe or redirect is emitted and drain_err clears.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- Event detect is evaluated only in IDLE and only when cmt_valid=1.
- Priority: irq = tmr_irq_pend & (cmt_pc!=0) wins over ecall, which wins over mret.
- On irq, the committing instruction is not retired; it is re-executed after return.
- IDLE -> DRAIN on any event, in the same cycle:
  - flush=1 for that cycle.
  - Latch kind (IRQ/ECALL/MRET).
  - Latch epc = {cmt_pc[XLEN-1:2],2'b00}.
  - Latch cause: ECALL=64'd11; IRQ=64'h8000_0000_0000_0007; MRET=don't care, driven 0.
- stall_req=1 in DRAIN, COMMIT and REDIRECT; 0 in IDLE.
- DRAIN:
  - Drain counter resets to 0 on entry and increments each cycle while mem_busy=1.
  - -> COMMIT when mem_busy=0.
  - Also -> COMMIT when the counter reaches DRAIN_TIMEOUT; set drain_err (sticky until rst).
  - Minimum one cycle in DRAIN.
- COMMIT:
  - If ex_stall=1, remain; no strobes.
  - Else assert exactly one strobe for one cycle: ecall_trap_ena (ECALL), tmr_trap_ena (IRQ) or cmt_mret_ena (MRET).
  - trap_mcause_value and trap_epc are valid in that cycle and are 0 otherwise.
  - Increment trap_cnt (IRQ/ECALL) or mret_cnt (MRET); counters wrap modulo 2^CNT_W.
  - -> REDIRECT.
- REDIRECT:
  - redirect_valid=1 for one cycle.
  - redirect_pc = {csr_mtvec[XLEN-1:2],2'b00} for IRQ/ECALL; csr_mepc for MRET. Sampled this cycle, after the CSR update edge.
  - -> IDLE.
- Outside IDLE, cmt_valid/ecall/mret/irq are ignored. Upstream guarantees cmt_valid=0 while stall_req=1, checked by assertion.
- A pending irq arriving the cycle after REDIRECT is a legal new event; back-to-back traps are allowed.
- Minimum event-to-redirect latency is 3 cycles: IDLE edge, DRAIN, COMMIT, with REDIRECT in the 4th cycle.

Test Plan:
- ecall at pc 0x8000_0104, mem_busy=0, mtvec=0x8000_0400 -> flush at cycle 0; ecall_trap_ena at cycle 2 with mcause=11, epc=0x8000_0104; redirect_pc=0x8000_0400 at cycle 3; trap_cnt=1.
- mret at pc 0x8000_0420, mepc=0x8000_0108 -> cmt_mret_ena only, no trap strobe; redirect_pc=0x8000_0108; mret_cnt=1.
- tmr_irq_pend=1 with cmt_ecall=1 at pc 0x8000_0200 -> tmr_trap_ena, mcause=0x8000_0000_0000_0007, epc=0x8000_0200; ecall_trap_ena stays 0.
- tmr_irq_pend=1 with cmt_pc=0 -> no event.
- mem_busy held 10 cycles, then ex_stall held 3 cycles in COMMIT -> strobe appears only after both clear, single cycle.
- mem_busy stuck 1 with DRAIN_TIMEOUT=255 -> COMMIT after 255 DRAIN cycles; drain_err=1 and stays set.
- rst pulsed during DRAIN, then ecall -> no strobe from the aborted event; drain_err=0; new event completes normally.

Source files
------------

// File: rtl/trap_seq_ctrl.sv
// Machine-mode trap entry / mret sequencer between commit and the CSR file.
// Stalls and flushes, drains memory traffic, strobes the CSR update once, then redirects fetch.
module trap_seq_ctrl #(
   parameter int XLEN          = 64,
   parameter int DRAIN_TIMEOUT = 255,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmt_valid,
   input  logic [XLEN-1:0]  cmt_pc,
   input  logic             cmt_ecall,
   input  logic             cmt_mret,
   input  logic             tmr_irq_pend,
   input  logic             mem_busy,
   input  logic             ex_stall,
   input  logic [XLEN-1:0]  csr_mtvec,
   input  logic [XLEN-1:0]  csr_mepc,
   output logic             stall_req,
   output logic             flush,
   output logic             ecall_trap_ena,
   output logic             tmr_trap_ena,
   output logic             cmt_mret_ena,
   output logic [XLEN-1:0]  trap_mcause_value,
   output logic [XLEN-1:0]  trap_epc,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             drain_err,
   output logic [CNT_W-1:0] trap_cnt,
   output logic [CNT_W-1:0] mret_cnt,
   output logic [1:0]       state_dbg
);
   localparam int DC_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
   localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, (XLEN-1)'(7)};
   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
   typedef enum logic [1:0] {K_NONE, K_IRQ, K_ECALL, K_MRET} kind_t;

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d;
   logic [XLEN-1:0]  epc_q, epc_d;
   logic [XLEN-1:0]  cause_q, cause_d;
   logic [DC_W-1:0]  dcnt_q;
   logic             irq_ev;
   logic             drain_to;
   logic             commit_fire;

   // A zero PC marks a bubble, so a pending interrupt cannot be attached to it.
   assign irq_ev    = tmr_irq_pend && (cmt_pc != '0);
   assign state_dbg = state_q;

   always_comb begin
      state_d           = state_q;
      kind_d            = kind_q;
      epc_d             = epc_q;
      cause_d           = cause_q;
      stall_req         = (state_q != IDLE);
      flush             = 1'b0;
      ecall_trap_ena    = 1'b0;
      tmr_trap_ena      = 1'b0;
      cmt_mret_ena      = 1'b0;
      trap_mcause_value = '0;
      trap_epc          = '0;
      redirect_valid    = 1'b0;
      redirect_pc       = '0;
      drain_to          = 1'b0;
      commit_fire       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmt_valid && (irq_ev || cmt_ecall || cmt_mret)) begin
               state_d = DRAIN;
               flush   = 1'b1;
               epc_d   = cmt_pc & ALIGN_MASK;
               if (irq_ev) begin
                  kind_d  = K_IRQ;
                  cause_d = CAUSE_IRQ;
               end else if (cmt_ecall) begin
                  kind_d  = K_ECALL;
                  cause_d = CAUSE_ECALL;
               end else begin
                  kind_d  = K_MRET;
                  cause_d = '0;
               end
            end
         end
         DRAIN: begin
            if (!mem_busy) begin
               state_d = COMMIT;
            end else if (dcnt_q == DC_W'(DRAIN_TIMEOUT - 1)) begin
               state_d  = COMMIT;
               drain_to = 1'b1;
            end
         end
         COMMIT: begin
            if (!ex_stall) begin
               commit_fire       = 1'b1;
               ecall_trap_ena    = (kind_q == K_ECALL);
               tmr_trap_ena      = (kind_q == K_IRQ);
               cmt_mret_ena      = (kind_q == K_MRET);
               trap_mcause_value = cause_q;
               trap_epc          = epc_q;
               state_d           = REDIRECT;
            end
         end
         REDIRECT: begin
            // CSR values are read here, one edge after the CSR update strobe.
            redirect_valid = 1'b1;
            redirect_pc    = (kind_q == K_MRET) ? csr_mepc : (csr_mtvec & ALIGN_MASK);
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         kind_q    <= K_NONE;
         epc_q     <= '0;
         cause_q   <= '0;
         dcnt_q    <= '0;
         drain_err <= 1'b0;
         trap_cnt  <= '0;
         mret_cnt  <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         if (state_q != DRAIN)
            dcnt_q <= '0;
         else if (mem_busy)
            dcnt_q <= dcnt_q + 1'b1;
         if (drain_to)
            drain_err <= 1'b1;
         if (commit_fire && (kind_q == K_MRET))
            mret_cnt <= mret_cnt + 1'b1;
         else if (commit_fire)
            trap_cnt <= trap_cnt + 1'b1;
      end
   end

   // Upstream must hold commit off while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(stall_req && cmt_valid));
   end
endmodule
